// File: rtl/stream_traffic_checker.sv
// Stream traffic checker: sends NUM_MSGS messages of BEATS_PER_MSG beats and scores the returned results.
// Optional rx back-pressure from a 16-bit LFSR is enabled by defining STREAM_CHECKER_BACKPRESSURE_EN.
module stream_traffic_checker #(
  parameter int unsigned DATA_W        = 255,
  parameter int unsigned BEATS_PER_MSG = 3,
  parameter int unsigned NUM_MSGS      = 100,
  parameter int unsigned TIMEOUT_CYC   = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] ref_input,
  input  logic [DATA_W-1:0] ref_output,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic [DATA_W-1:0] tx_payload,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              rx_last,
  input  logic [DATA_W-1:0] rx_payload,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [15:0]       rx_count
);

  localparam int unsigned TOTAL_BEATS = NUM_MSGS * BEATS_PER_MSG;
  localparam int unsigned BEAT_W      = (BEATS_PER_MSG > 1) ? $clog2(BEATS_PER_MSG) : 1;
  localparam int unsigned SENT_W      = $clog2(TOTAL_BEATS + 1);
  localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST     = BEAT_W'(BEATS_PER_MSG - 1);
  localparam logic              LAST_ON_FIRST = (BEATS_PER_MSG == 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_idx;
  logic [SENT_W-1:0] sent_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              active_c;
  logic              start_ok_c;
  logic              tx_hs_c;
  logic              rx_hs_c;
  logic              rx_bad_c;
  logic              rx_final_c;
  logic              tmo_fire_c;
  logic              tx_final_c;
  logic [BEAT_W-1:0] beat_nxt_c;
  logic [15:0]       err_next_c;
  logic              rdy_adv_c;

  // Handshake decode, saturating error update and run-termination conditions
  always_comb begin
    active_c   = (state == S_RUN) || (state == S_DRAIN);
    start_ok_c = start && ((state == S_IDLE) || (state == S_DONE));
    tx_hs_c    = (state == S_RUN) && tx_valid && tx_ready;
    rx_hs_c    = active_c && rx_valid && rx_ready;
    rx_bad_c   = rx_hs_c && ((rx_payload != ref_output) || !rx_last);
    err_next_c = err_count;
    if (rx_bad_c && (err_count != 16'hFFFF)) err_next_c = err_count + 16'd1;
    rx_final_c = rx_hs_c && (rx_count == 16'(NUM_MSGS - 1));
    tmo_fire_c = active_c && !rx_hs_c && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    tx_final_c = sent_cnt == SENT_W'(TOTAL_BEATS - 1);
    beat_nxt_c = (beat_idx == BEAT_LAST) ? '0 : beat_idx + BEAT_W'(1);
  end

`ifdef STREAM_CHECKER_BACKPRESSURE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic        RDY_SEED  = LFSR_SEED[0];

  logic [15:0] lfsr;
  logic [15:0] lfsr_next_c;

  // Fibonacci LFSR, taps 16,14,13,11; rx_ready follows its bit 0 while a run is active
  always_comb begin
    lfsr_next_c = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    rdy_adv_c   = lfsr_next_c[0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         lfsr <= LFSR_SEED;
    else if (start_ok_c) lfsr <= LFSR_SEED;
    else                 lfsr <= lfsr_next_c;
  end
`else
  localparam logic RDY_SEED = 1'b1;

  always_comb rdy_adv_c = 1'b1;
`endif

  // Run control: tx beat generation, rx scoring and status outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      beat_idx   <= '0;
      sent_cnt   <= '0;
      tmo_cnt    <= '0;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      tx_payload <= '0;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      rx_count   <= '0;
    end else if (start_ok_c) begin
      state      <= S_RUN;
      beat_idx   <= '0;
      sent_cnt   <= '0;
      tmo_cnt    <= '0;
      tx_valid   <= 1'b1;
      tx_last    <= LAST_ON_FIRST;
      tx_payload <= ref_input;
      rx_ready   <= RDY_SEED;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      rx_count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: rx_ready <= 1'b1;
        S_RUN, S_DRAIN: begin
          rx_ready <= rdy_adv_c;
          if (rx_hs_c) begin
            rx_count  <= rx_count + 16'd1;
            err_count <= err_next_c;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
          if (tx_hs_c) begin
            sent_cnt <= sent_cnt + SENT_W'(1);
            if (tx_final_c) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              state    <= S_DRAIN;
            end else begin
              beat_idx   <= beat_nxt_c;
              tx_payload <= ref_input;
              tx_last    <= (beat_nxt_c == BEAT_LAST);
            end
          end
          // Run ends on the final result or on a silent result stream
          if (rx_final_c || tmo_fire_c) begin
            state    <= S_DONE;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= tmo_fire_c;
            pass     <= (err_next_c == 16'd0) && !tmo_fire_c;
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_traffic_checker.md
STREAM_TRAFFIC_CHECKER -- requirements
Module: stream_traffic_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 255, stream payload width.
REQ-002 SHALL have parameter BEATS_PER_MSG, default 3, number of input beats per message; the last beat of each message carries tx_last.
REQ-003 SHALL have parameter NUM_MSGS, default 100, number of messages sent and number of result beats expected.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, maximum cycles allowed between consecutive result handshakes.
REQ-005 SHALL have port clk input 1, the single clock, rising edge.
REQ-006 SHALL have port resetn input 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start input 1, a one-cycle pulse that launches a run.
REQ-008 SHALL have port ref_input input DATA_W, the payload driven on every input beat.
REQ-009 SHALL have port ref_output input DATA_W, the expected payload of every result beat.
REQ-010 SHALL have ports tx_valid output 1, tx_ready input 1, tx_last output 1, tx_payload output DATA_W, the stream driven into the DUT.
REQ-011 SHALL have ports rx_valid input 1, rx_ready output 1, rx_last input 1, rx_payload input DATA_W, the DUT result stream.
REQ-012 SHALL have ports busy, done, pass, timeout, each output 1, for run status.
REQ-013 SHALL have ports err_count output 16 and rx_count output 16, the mismatch count and the received-beat count.

Function
REQ-014 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-015 SHALL transition IDLE->RUN on start, clear both counters, and assert busy while in RUN or DRAIN.
REQ-016 SHALL, in RUN, assert tx_valid and drive tx_payload=ref_input, registered.
REQ-017 SHALL hold tx_valid, tx_payload and tx_last stable while tx_valid=1 and tx_ready=0, and SHALL never deassert tx_valid before its handshake.
REQ-018 SHALL count beats modulo BEATS_PER_MSG and assert tx_last on beat BEATS_PER_MSG-1; if BEATS_PER_MSG=1, every beat is last.
REQ-019 SHALL advance to the next beat in the cycle after the handshake with no bubble (one beat per cycle at full throughput).
REQ-020 SHALL, after the handshake of beat NUM_MSGS*BEATS_PER_MSG, drop tx_valid in the next cycle and go RUN->DRAIN.
REQ-021 SHALL, on each rx handshake (rx_valid & rx_ready), increment rx_count and, if rx_payload!=ref_output or rx_last=0, increment err_count, saturating at 16'hFFFF.
REQ-022 SHALL check rx handshakes in both RUN and DRAIN, since results may arrive while input is still being sent.
REQ-023 SHALL go to DONE when rx_count reaches NUM_MSGS, from RUN or DRAIN.
REQ-024 SHALL, in DONE, assert done=1 and pass=(err_count==0 && !timeout), deassert tx_valid and rx_ready, and ignore further rx beats.
REQ-025 SHALL run a timeout counter that resets on every rx handshake and on start, and SHALL go to DONE with timeout=1 when it reaches TIMEOUT_CYC.
REQ-026 SHALL treat start in DONE as a new run (DONE->RUN with counters and flags cleared), and SHALL ignore start in RUN or DRAIN.
REQ-027 SHALL, when an rx handshake coincides with the final tx handshake, count both events in that cycle.

Reset
REQ-028 SHALL, on resetn=0, asynchronously enter IDLE with tx_valid=0, tx_last=0, tx_payload=0, rx_ready=0, busy=0, done=0, pass=0, timeout=0, err_count=0 and rx_count=0.
REQ-029 SHALL abandon a run in progress on reset without emitting any further beat, and SHALL require a new start after reset deasserts.
REQ-030 SHALL drive rx_ready=1 in IDLE after reset.

Configuration
REQ-031 SHALL use macro STREAM_CHECKER_BACKPRESSURE_EN.
- When defined: rx_ready in RUN and DRAIN equals bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that advances every cycle; the LFSR resets to the seed on resetn and on start.
- When undefined: rx_ready=1 in IDLE, RUN and DRAIN, and no LFSR is present.

Verification
REQ-032 SHALL cover: tx_ready=1, DUT echo model returning ref_output on each tx_last -> 300 tx beats, tx_last on beats 2,5,8..., done with pass=1, rx_count=100, err_count=0.
REQ-033 SHALL cover: tx_ready low for 5 cycles mid-message -> tx_payload and tx_last remain unchanged across the stall, beat count stays 300.
REQ-034 SHALL cover: model corrupts result beats 7 and 42 -> done with pass=0, err_count=2.
REQ-035 SHALL cover: model stops returning results after 10 beats, TIMEOUT_CYC=64 -> timeout=1 and done 64 cycles after the 10th handshake, pass=0.
REQ-036 SHALL cover: resetn pulsed low during beat 150 -> all outputs read reset values immediately; a new start yields a full, clean run.
REQ-037 SHALL cover: with STREAM_CHECKER_BACKPRESSURE_EN defined -> rx_ready follows the LFSR sequence from seed 16'hACE1 and pass=1 is still reached.
